// File: rtl/cpu_run_monitor_pkg.sv
// Shared definitions for the CPU run monitor: state encoding and default parameter values.
package cpu_run_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_STARTUP = 3'd1,
      ST_RUN     = 3'd2,
      ST_CHECK   = 3'd3,
      ST_DONE    = 3'd4
   } state_e;

   localparam int DEF_PC_WIDTH    = 32;
   localparam int DEF_DATA_WIDTH  = 32;
   localparam int DEF_NUM_CHECKS  = 4;
   localparam int DEF_CNT_WIDTH   = 16;
   localparam int DEF_MAX_CYCLES  = 1000;
   localparam int DEF_START_DELAY = 2;
   localparam int DEF_HALT_REPEAT = 2;

endpackage

// File: rtl/cpu_run_monitor_halt_detector.sv
// Halt detector: flags a CPU halt once the PC has repeated itself HALT_REPEAT
// consecutive cycles. History is discarded whenever the detector is disabled,
// so the first enabled cycle never counts as a repeat.
module halt_detector
   import cpu_run_pkg::*;
#(
   parameter int PC_WIDTH    = DEF_PC_WIDTH,
   parameter int HALT_REPEAT = DEF_HALT_REPEAT
)
(
   input  logic                clk,
   input  logic                reset,
   input  logic                en,
   input  logic [PC_WIDTH-1:0] pc,
   output logic                halted
);

   localparam int            RW      = (HALT_REPEAT < 2) ? 1 : $clog2(HALT_REPEAT + 1);
   localparam logic [RW-1:0] REP_LIM = RW'(HALT_REPEAT);
   localparam logic [RW-1:0] REP_ONE = RW'(1);

   logic [PC_WIDTH-1:0] prev_pc_q, prev_pc_d;
   logic                prev_vld_q, prev_vld_d;
   logic [RW-1:0]       rep_q, rep_d;

   // Next-state for PC history and the saturating repeat counter.
   always_comb begin
      prev_pc_d  = prev_pc_q;
      prev_vld_d = prev_vld_q;
      rep_d      = rep_q;
      if (en) begin
         prev_pc_d  = pc;
         prev_vld_d = 1'b1;
         if (prev_vld_q && (pc == prev_pc_q)) begin
            if (rep_q != REP_LIM) begin
               rep_d = rep_q + REP_ONE;
            end else begin
               rep_d = rep_q;
            end
         end else begin
            rep_d = {RW{1'b0}};
         end
      end else begin
         prev_vld_d = 1'b0;
         rep_d      = {RW{1'b0}};
      end
   end

   // History and counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_pc_q  <= {PC_WIDTH{1'b0}};
         prev_vld_q <= 1'b0;
         rep_q      <= {RW{1'b0}};
      end else begin
         prev_pc_q  <= prev_pc_d;
         prev_vld_q <= prev_vld_d;
         rep_q      <= rep_d;
      end
   end

   // Halt is signalled in the cycle whose PC completes the repeat run.
   assign halted = en && (rep_d == REP_LIM);

endmodule

// File: rtl/cpu_run_monitor.sv
// Run controller and verdict monitor for the single-cycle CPU: releases the
// CPU after a start delay, counts run cycles, stops on halt or timeout, then
// compares the observed architectural values one channel per cycle.
module cpu_run_monitor
   import cpu_run_pkg::*;
#(
   parameter int PC_WIDTH    = DEF_PC_WIDTH,
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int NUM_CHECKS  = DEF_NUM_CHECKS,
   parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
   parameter int MAX_CYCLES  = DEF_MAX_CYCLES,
   parameter int START_DELAY = DEF_START_DELAY,
   parameter int HALT_REPEAT = DEF_HALT_REPEAT
)
(
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             go,
   input  logic [PC_WIDTH-1:0]              pc,
   input  logic [NUM_CHECKS*DATA_WIDTH-1:0] chk_data,
   input  logic [NUM_CHECKS*DATA_WIDTH-1:0] chk_expect,
   input  logic [NUM_CHECKS-1:0]            chk_enable,
   output logic                             cpu_start,
   output logic                             running,
   output logic                             done,
   output logic                             passed,
   output logic                             timeout,
   output logic [CNT_WIDTH-1:0]             cycle_count,
   output logic [NUM_CHECKS-1:0]            fail_mask
);

   localparam int                   IDX_W    = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;
   localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_CHECKS - 1);
   localparam logic [IDX_W-1:0]     IDX_ONE  = IDX_W'(1);
   localparam logic [CNT_WIDTH-1:0] MAX_LIM  = CNT_WIDTH'(MAX_CYCLES);
   localparam logic [CNT_WIDTH-1:0] DLY_LIM  = CNT_WIDTH'(START_DELAY);

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      if (v == {CNT_WIDTH{1'b1}}) begin
         return v;
      end else begin
         return v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
   endfunction

   // True when the selected channel's observed value differs from its expectation.
   function automatic logic chan_mismatch(input logic [NUM_CHECKS*DATA_WIDTH-1:0] d,
                                          input logic [NUM_CHECKS*DATA_WIDTH-1:0] e,
                                          input logic [IDX_W-1:0]                 i);
      return d[i*DATA_WIDTH +: DATA_WIDTH] != e[i*DATA_WIDTH +: DATA_WIDTH];
   endfunction

   state_e                state_q, state_d;
   logic [CNT_WIDTH-1:0]  dly_q, dly_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [CNT_WIDTH-1:0]  cycle_count_q, cycle_count_d;
   logic [NUM_CHECKS-1:0] fail_mask_q, fail_mask_d;
   logic                  halted_q, halted_d;
   logic                  passed_q, passed_d;
   logic                  timeout_q, timeout_d;
   logic                  cpu_start_q, cpu_start_d;
   logic                  running_q, running_d;
   logic                  done_q, done_d;
   logic                  halt_hit_s;

   halt_detector #(
      .PC_WIDTH    (PC_WIDTH),
      .HALT_REPEAT (HALT_REPEAT)
   ) u_halt (
      .clk    (clk),
      .reset  (reset),
      .en     (state_q == ST_RUN),
      .pc     (pc),
      .halted (halt_hit_s)
   );

   // Run sequencer: next state, counters, verdict and decoded outputs.
   always_comb begin
      state_d       = state_q;
      dly_d         = dly_q;
      idx_d         = idx_q;
      cycle_count_d = cycle_count_q;
      fail_mask_d   = fail_mask_q;
      halted_d      = halted_q;
      passed_d      = passed_q;
      timeout_d     = timeout_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (go) begin
               state_d       = ST_STARTUP;
               dly_d         = {CNT_WIDTH{1'b0}};
               cycle_count_d = {CNT_WIDTH{1'b0}};
               fail_mask_d   = {NUM_CHECKS{1'b0}};
               halted_d      = 1'b0;
               passed_d      = 1'b0;
               timeout_d     = 1'b0;
            end else begin
               state_d = state_q;
            end
         end
         ST_STARTUP: begin
            // At least one STARTUP cycle, even with no requested delay.
            if (sat_inc(dly_q) >= DLY_LIM) begin
               state_d = ST_RUN;
            end else begin
               dly_d = sat_inc(dly_q);
            end
         end
         ST_RUN: begin
            cycle_count_d = sat_inc(cycle_count_q);
            idx_d         = {IDX_W{1'b0}};
            // Halt has priority when it coincides with the cycle limit.
            if (halt_hit_s) begin
               state_d   = ST_CHECK;
               halted_d  = 1'b1;
               timeout_d = 1'b0;
            end else if (cycle_count_d >= MAX_LIM) begin
               state_d   = ST_CHECK;
               halted_d  = 1'b0;
               timeout_d = 1'b1;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_CHECK: begin
            fail_mask_d[idx_q] = chk_enable[idx_q] && chan_mismatch(chk_data, chk_expect, idx_q);
            if (idx_q == LAST_IDX) begin
               state_d  = ST_DONE;
               passed_d = halted_q && (fail_mask_d == {NUM_CHECKS{1'b0}});
            end else begin
               idx_d = idx_q + IDX_ONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      cpu_start_d = (state_d == ST_RUN);
      running_d   = (state_d == ST_STARTUP) || (state_d == ST_RUN);
      done_d      = (state_d == ST_DONE);
   end

   // State and output registers; reset drops cpu_start immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         dly_q         <= {CNT_WIDTH{1'b0}};
         idx_q         <= {IDX_W{1'b0}};
         cycle_count_q <= {CNT_WIDTH{1'b0}};
         fail_mask_q   <= {NUM_CHECKS{1'b0}};
         halted_q      <= 1'b0;
         passed_q      <= 1'b0;
         timeout_q     <= 1'b0;
         cpu_start_q   <= 1'b0;
         running_q     <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         dly_q         <= dly_d;
         idx_q         <= idx_d;
         cycle_count_q <= cycle_count_d;
         fail_mask_q   <= fail_mask_d;
         halted_q      <= halted_d;
         passed_q      <= passed_d;
         timeout_q     <= timeout_d;
         cpu_start_q   <= cpu_start_d;
         running_q     <= running_d;
         done_q        <= done_d;
      end
   end

   assign cpu_start   = cpu_start_q;
   assign running     = running_q;
   assign done        = done_q;
   assign passed      = passed_q;
   assign timeout     = timeout_q;
   assign cycle_count = cycle_count_q;
   assign fail_mask   = fail_mask_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Directed bench for cpu_run_monitor (MAX_CYCLES = 10, other parameters default).
module tb_cpu_run_monitor;

   logic         clk;
   logic         reset;
   logic         go;
   logic [31:0]  pc;
   logic [127:0] chk_data;
   logic [127:0] chk_expect;
   logic [3:0]   chk_enable;
   logic         cpu_start;
   logic         running;
   logic         done;
   logic         passed;
   logic         timeout;
   logic [15:0]  cycle_count;
   logic [3:0]   fail_mask;

   int vectors = 0;
   int errors  = 0;

   logic [31:0] pc_seq[$];
   bit          pc_inc;
   int          rel_to_done;
   logic [2:0]  st_seq;
   logic        ent_running, ent_passed, ent_timeout;
   logic [3:0]  ent_mask;
   logic [15:0] ent_cc;

   cpu_run_monitor #(
      .PC_WIDTH    (32),
      .DATA_WIDTH  (32),
      .NUM_CHECKS  (4),
      .CNT_WIDTH   (16),
      .MAX_CYCLES  (10),
      .START_DELAY (2),
      .HALT_REPEAT (2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .go          (go),
      .pc          (pc),
      .chk_data    (chk_data),
      .chk_expect  (chk_expect),
      .chk_enable  (chk_enable),
      .cpu_start   (cpu_start),
      .running     (running),
      .done        (done),
      .passed      (passed),
      .timeout     (timeout),
      .cycle_count (cycle_count),
      .fail_mask   (fail_mask)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // All channels enabled and matching.
   task automatic set_channels_ok();
      chk_expect = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0010};
      chk_data   = chk_expect;
      chk_enable = 4'b1111;
   endtask

   // Pulse go from a negedge and record the three cycles that follow.
   task automatic launch();
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      st_seq[0]   = cpu_start;
      ent_running = running;
      ent_passed  = passed;
      ent_timeout = timeout;
      ent_mask    = fail_mask;
      ent_cc      = cycle_count;
      @(negedge clk);
      st_seq[1] = cpu_start;
      @(negedge clk);
      st_seq[2] = cpu_start;
   endtask

   // Feed pc_seq (then hold or +4) until done; go pulses at relative cycles go_a/go_b.
   task automatic run_and_wait(input int go_a, input int go_b);
      int idx;
      idx = 0;
      rel_to_done = 0;
      while (done !== 1'b1 && rel_to_done < 100) begin
         if (idx < pc_seq.size()) pc = pc_seq[idx];
         else if (pc_inc) pc = pc + 32'd4;
         go = (rel_to_done == go_a) || (rel_to_done == go_b);
         idx++;
         @(negedge clk);
         rel_to_done++;
      end
      go = 1'b0;
      vectors++;
      if (done !== 1'b1) begin errors++; $display("FAIL done_wait: done=%b after %0d cycles, required 1", done, rel_to_done); end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      vectors++; if (cpu_start !== 1'b0) begin errors++; $display("FAIL rst_cpu_start: got %b want 0", cpu_start); end
      vectors++; if (running !== 1'b0) begin errors++; $display("FAIL rst_running: got %b want 0", running); end
      vectors++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
      vectors++; if ({passed, timeout} !== 2'b00) begin errors++; $display("FAIL rst_verdict: got %b want 00", {passed, timeout}); end
      vectors++; if (cycle_count !== 16'd0) begin errors++; $display("FAIL rst_cycles: got %0d want 0", cycle_count); end
      vectors++; if (fail_mask !== 4'b0000) begin errors++; $display("FAIL rst_mask: got %b want 0000", fail_mask); end
      reset = 1'b0;
      repeat (2) @(negedge clk);
      vectors++; if (running !== 1'b0) begin errors++; $display("FAIL idle_running: got %b want 0", running); end
   endtask

   task automatic test_halt_pass();
      set_channels_ok();
      pc_seq = {32'd0, 32'd4, 32'd8, 32'd12, 32'd12, 32'd12};
      pc_inc = 1'b0;
      launch();
      vectors++; if (st_seq !== 3'b100) begin errors++; $display("FAIL t1_start_seq: got %b want 100", st_seq); end
      vectors++; if (ent_running !== 1'b1) begin errors++; $display("FAIL t1_startup_running: got %b want 1", ent_running); end
      run_and_wait(-1, -1);
      vectors++; if (rel_to_done !== 10) begin errors++; $display("FAIL t1_latency: got %0d want 10", rel_to_done); end
      vectors++; if (cycle_count !== 16'd6) begin errors++; $display("FAIL t1_cycles: got %0d want 6", cycle_count); end
      vectors++; if ({passed, timeout} !== 2'b10) begin errors++; $display("FAIL t1_verdict: got %b want 10", {passed, timeout}); end
      vectors++; if (fail_mask !== 4'b0000) begin errors++; $display("FAIL t1_mask: got %b want 0000", fail_mask); end
      vectors++; if ({cpu_start, running} !== 2'b00) begin errors++; $display("FAIL t1_done_ctrl: got %b want 00", {cpu_start, running}); end
      repeat (3) @(negedge clk);
      vectors++; if ({done, passed, cycle_count} !== {1'b1, 1'b1, 16'd6}) begin errors++; $display("FAIL t1_hold: got %b/%b/%0d want 1/1/6", done, passed, cycle_count); end
   endtask

   task automatic test_mismatch();
      set_channels_ok();
      chk_expect[2*32 +: 32] = 32'h0000_0005;
      chk_data[2*32 +: 32]   = 32'h0000_0007;
      chk_data[3*32 +: 32]   = 32'hBAD0_BAD0;
      chk_enable             = 4'b0111;
      pc_seq = {32'd0, 32'd4, 32'd8, 32'd12, 32'd12, 32'd12};
      pc_inc = 1'b0;
      launch();
      vectors++; if ({ent_passed, ent_cc} !== {1'b0, 16'd0}) begin errors++; $display("FAIL t2_entry_clear: got %b/%0d want 0/0", ent_passed, ent_cc); end
      run_and_wait(-1, -1);
      vectors++; if ({passed, timeout} !== 2'b00) begin errors++; $display("FAIL t2_verdict: got %b want 00", {passed, timeout}); end
      vectors++; if (fail_mask !== 4'b0100) begin errors++; $display("FAIL t2_mask: got %b want 0100", fail_mask); end
   endtask

   task automatic test_timeout();
      set_channels_ok();
      chk_data[1*32 +: 32] = 32'h0000_0009;
      pc_seq = {32'd0};
      pc_inc = 1'b1;
      launch();
      vectors++; if (ent_mask !== 4'b0000) begin errors++; $display("FAIL t3_entry_mask: got %b want 0000", ent_mask); end
      run_and_wait(-1, -1);
      vectors++; if (rel_to_done !== 14) begin errors++; $display("FAIL t3_latency: got %0d want 14", rel_to_done); end
      vectors++; if (cycle_count !== 16'd10) begin errors++; $display("FAIL t3_cycles: got %0d want 10", cycle_count); end
      vectors++; if ({passed, timeout} !== 2'b01) begin errors++; $display("FAIL t3_verdict: got %b want 01", {passed, timeout}); end
      vectors++; if (fail_mask !== 4'b0010) begin errors++; $display("FAIL t3_mask: got %b want 0010", fail_mask); end
   endtask

   task automatic test_halt_at_limit();
      set_channels_ok();
      pc_seq = {32'd0, 32'd4, 32'd8, 32'd12, 32'd16, 32'd20, 32'd24, 32'd28};
      pc_inc = 1'b0;
      launch();
      vectors++; if (ent_timeout !== 1'b0) begin errors++; $display("FAIL t4_entry_timeout: got %b want 0", ent_timeout); end
      run_and_wait(-1, -1);
      vectors++; if (cycle_count !== 16'd10) begin errors++; $display("FAIL t4_cycles: got %0d want 10", cycle_count); end
      vectors++; if ({passed, timeout} !== 2'b10) begin errors++; $display("FAIL t4_verdict: got %b want 10", {passed, timeout}); end
   endtask

   task automatic test_reset_mid_run();
      set_channels_ok();
      launch();
      pc = 32'd0;  @(negedge clk);
      pc = 32'd4;  @(negedge clk);
      pc = 32'd8;  @(negedge clk);
      vectors++; if (cycle_count !== 16'd3) begin errors++; $display("FAIL t5_counting: got %0d want 3", cycle_count); end
      #2 reset = 1'b1;
      #1;
      vectors++; if ({cpu_start, running} !== 2'b00) begin errors++; $display("FAIL t5_async_ctrl: got %b want 00", {cpu_start, running}); end
      vectors++; if (cycle_count !== 16'd0) begin errors++; $display("FAIL t5_async_cycles: got %0d want 0", cycle_count); end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      pc_seq = {32'd0, 32'd4, 32'd8, 32'd12, 32'd12, 32'd12};
      pc_inc = 1'b0;
      launch();
      vectors++; if (st_seq !== 3'b100) begin errors++; $display("FAIL t5_restart_seq: got %b want 100", st_seq); end
      run_and_wait(-1, -1);
      vectors++; if ({passed, cycle_count} !== {1'b1, 16'd6}) begin errors++; $display("FAIL t5_restart_result: got %b/%0d want 1/6", passed, cycle_count); end
   endtask

   task automatic test_back_to_back();
      set_channels_ok();
      pc_seq = {32'd0, 32'd4, 32'd8, 32'd12, 32'd12, 32'd12};
      pc_inc = 1'b0;
      launch();
      run_and_wait(2, 7);
      vectors++; if (rel_to_done !== 10) begin errors++; $display("FAIL t6_latency: got %0d want 10", rel_to_done); end
      vectors++; if ({passed, cycle_count} !== {1'b1, 16'd6}) begin errors++; $display("FAIL t6_result: got %b/%0d want 1/6", passed, cycle_count); end
      launch();
      vectors++; if ({ent_running, ent_passed, ent_timeout} !== 3'b100) begin errors++; $display("FAIL t6_done_go: got %b want 100", {ent_running, ent_passed, ent_timeout}); end
      vectors++; if ({ent_mask, ent_cc} !== {4'b0000, 16'd0}) begin errors++; $display("FAIL t6_entry_clear: got %b/%0d want 0000/0", ent_mask, ent_cc); end
      run_and_wait(-1, -1);
      vectors++; if ({passed, timeout} !== 2'b10) begin errors++; $display("FAIL t6_second_verdict: got %b want 10", {passed, timeout}); end
   endtask

   initial begin
      reset  = 1'b1;
      go     = 1'b0;
      pc     = 32'd0;
      pc_inc = 1'b0;
      set_channels_ok();
      test_reset();
      test_halt_pass();
      test_mismatch();
      test_timeout();
      test_halt_at_limit();
      test_reset_mid_run();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/cpu_run_monitor.md
Name: cpu_run_monitor

Overview:
Synthesizable run controller and self-checking monitor for the single-cycle CPU. It:
- sequences the CPU's start input;
- counts executed cycles;
- detects program halt (PC self-loop) or timeout;
- compares up to NUM_CHECKS observed architectural values against expected values.

It sits beside the cpu instance in the top-level bench/FPGA wrapper and replaces a fixed-duration run with a verdict of pass, fail or timeout.

Parameters:
PC_WIDTH, 32, width of observed program counter
DATA_WIDTH, 32, width of each check channel
NUM_CHECKS, 4, number of compare channels (1..16)
CNT_WIDTH, 16, cycle counter width
MAX_CYCLES, 1000, run cycles before timeout is declared (must be < 2**CNT_WIDTH)
START_DELAY, 2, cycles cpu_start is held low after go before release
HALT_REPEAT, 2, consecutive cycles of unchanged PC that constitute halt

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
go  in  1  one-cycle pulse: begin a run (ignored unless IDLE or DONE)
pc  in  PC_WIDTH  CPU program counter, sampled every cycle
chk_data  in  NUM_CHECKS*DATA_WIDTH  observed values, channel i at bits [i*DATA_WIDTH +: DATA_WIDTH]
chk_expect  in  NUM_CHECKS*DATA_WIDTH  expected values, same packing
chk_enable  in  NUM_CHECKS  per-channel compare enable
cpu_start  out  1  drives the CPU start input
running  out  1  high in STARTUP and RUN
done  out  1  high in DONE
passed  out  1  valid when done: halted and no enabled channel mismatched
timeout  out  1  valid when done: run ended by MAX_CYCLES
cycle_count  out  CNT_WIDTH  cycles spent in RUN, frozen after RUN exits
fail_mask  out  NUM_CHECKS  bit i set if channel i enabled and mismatched

Behaviour:
Reset (asynchronous, any state):
- State = IDLE.
- All outputs 0; cycle_count = 0; fail_mask = 0.
- Internal PC history register and halt counter cleared.

FSM states: IDLE, STARTUP, RUN, CHECK, DONE.

IDLE:
- cpu_start = 0.
- go -> STARTUP; clear cycle_count, fail_mask, passed, timeout and the delay counter.

STARTUP:
- cpu_start = 0; counts START_DELAY cycles.
- Then -> RUN with cpu_start = 1 from the first RUN cycle.
- START_DELAY = 0 passes through in exactly one cycle.

RUN:
- cpu_start = 1; cycle_count increments each cycle.
- Halt detection: if pc equals the previous-cycle pc, the halt counter increments; otherwise it resets to 0.
  - The first RUN cycle has no valid previous pc and never counts.
- Exit conditions:
  - Halt counter reaches HALT_REPEAT -> CHECK, halted flag = 1.
  - Otherwise, cycle_count reaches MAX_CYCLES -> CHECK, timeout = 1, halted = 0.
  - Both in the same cycle: halt wins; timeout stays 0.
- cycle_count saturates; it never wraps.

CHECK:
- cpu_start = 0 (CPU frozen).
- Walks index 0..NUM_CHECKS-1, one channel per cycle.
- fail_mask[i] = chk_enable[i] && (chk_data slice i != chk_expect slice i).
- Takes exactly NUM_CHECKS cycles, then -> DONE.
- Channels are checked even on timeout.

DONE:
- done = 1.
- passed = halted && (fail_mask == 0).
- Outputs held stable.
- go -> STARTUP (new run; verdict cleared on entry).

Other rules:
- go in STARTUP, RUN or CHECK is ignored.
- Reset mid-run aborts immediately; cpu_start drops asynchronously.
- Latency from go to first cpu_start = 1: START_DELAY + 1 cycles.
- Latency from halt detection to done: NUM_CHECKS + 1 cycles.

Decomposition:
- Shared package cpu_run_pkg holds:
  - state encoding constants (IDLE = 0, STARTUP = 1, RUN = 2, CHECK = 3, DONE = 4; 3-bit);
  - default parameter constants.
- One sub-module is natural: halt_detector (pc history register, equality compare, repeat counter, halted output), parametrised by PC_WIDTH and HALT_REPEAT.

Test Plan:
1. PC sequence 0,4,8,12,12,12 after release; all 4 channels enabled and matching; defaults -> cycle_count = 6, done after 4 CHECK cycles, passed = 1, timeout = 0, fail_mask = 0000.
2. Same as 1, but channel 2 expect = 32'h0000_0005 vs data 32'h0000_0007 -> passed = 0, fail_mask = 0100; channel 3 mismatched with chk_enable[3] = 0 -> bit 3 stays 0.
3. PC increments by 4 forever, MAX_CYCLES = 10 -> cycle_count = 10, timeout = 1, passed = 0, done asserted 10 + NUM_CHECKS cycles after release.
4. Halt and MAX_CYCLES reached on the same cycle (MAX_CYCLES = 5, PC 0,4,8,8,8) -> timeout = 0, passed = 1.
5. Reset asserted mid-RUN between clock edges -> cpu_start, running and cycle_count go to 0 without waiting for an edge; a subsequent go restarts cleanly with cpu_start low for START_DELAY = 2 cycles.
6. go pulsed during RUN and CHECK -> ignored; go in DONE -> new run with passed/timeout/fail_mask cleared on the STARTUP entry cycle.
